inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder.sv | 128 ++++++++++++
 tb/tb_inst_encoder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// inst_encoder
//   Encodes raw RISC-V instruction fields into a 32-bit instruction word and
//   range-checks the immediate. Each encoded word travels with its error flag
//   through a 2-entry FIFO that uses a valid/ready handshake on both sides.
//
// Ports
//   CLK, Reset          clock and synchronous active-high reset
//   in_valid/in_ready   request handshake (in_ready = FIFO not full)
//   fmt                 0=I 1=S 2=B 3=U 4=J 5=R, 6..7 illegal
//   opcode..funct7      raw instruction fields
//   imm                 unshifted immediate, as produced by the decoder
//   ExtSel              1 = signed range check, 0 = unsigned range check
//   out_valid/out_ready output handshake; inst/err show the FIFO head
//   count               completed output handshakes, wraps at 16 bits
module inst_encoder (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    input  logic        ExtSel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] inst,
    output logic        err,
    output logic [15:0] count
);

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } entry_t;

    entry_t     enc;
    entry_t     mem [2];
    logic       wptr, rptr;
    logic [1:0] occ;
    logic       full, push, pop;

    // Bits above the field are a pure sign extension: all ones or all zeros.
    function automatic logic not_sext(input logic [20:0] v, input int unsigned w);
        logic all1, all0;
        all1 = 1'b1;
        all0 = 1'b1;
        for (int i = 0; i < 21; i++) begin
            if (i < w) begin
                all1 &= v[i];
                all0 &= ~v[i];
            end
        end
        return !(all1 | all0);
    endfunction

    always_comb begin
        enc.inst = 32'h0;
        enc.err  = 1'b0;
        case (fmt)
            3'd0: begin
                enc.inst = {imm[11:0], rs1, funct3, rd, opcode};
                enc.err  = ExtSel ? not_sext(imm[31:11], 21) : |imm[31:12];
            end
            3'd1: begin
                enc.inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                enc.err  = ExtSel ? not_sext(imm[31:11], 21) : |imm[31:12];
            end
            3'd2: begin
                enc.inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                enc.err  = imm[0] | (ExtSel ? not_sext({1'b0, imm[31:12]}, 20) : |imm[31:13]);
            end
            3'd3: begin
                enc.inst = {imm[19:0], rd, opcode};
                enc.err  = |imm[31:20];
            end
            3'd4: begin
                enc.inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                enc.err  = imm[0] | (ExtSel ? not_sext({9'b0, imm[31:20]}, 12) : |imm[31:21]);
            end
            3'd5: begin
                enc.inst = {funct7, rs2, rs1, funct3, rd, opcode};
                enc.err  = 1'b0;
            end
            default: begin
                enc.inst = 32'h0;
                enc.err  = 1'b1;
            end
        endcase
    end

    // in_ready looks only at the registered occupancy, so a pop in the full
    // cycle never frees a slot for a same-cycle push. Reset forces it high.
    assign full      = (occ == 2'd2);
    assign in_ready  = Reset | ~full;
    assign push      = in_valid & ~full;
    assign out_valid = (occ != 2'd0);
    assign pop       = out_valid & out_ready;
    assign inst      = mem[rptr].inst;
    assign err       = mem[rptr].err;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            // Storage is cleared too so the idle head reads as zero.
            mem[0] <= '0;
            mem[1] <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            occ    <= 2'd0;
            count  <= 16'h0;
        end else begin
            if (push) begin
                mem[wptr] <= enc;
                wptr      <= ~wptr;
            end
            if (pop) begin
                rptr  <= ~rptr;
                count <= count + 16'h1;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

    logic        CLK = 1'b0;
    logic        Reset, in_valid, in_ready, ExtSel, out_valid, out_ready, err;
    logic [2:0]  fmt, funct3;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, inst;
    logic [15:0] count;

    int checks = 0;
    int errors = 0;

    // Reference state: queue of expected {err, inst} and expected count.
    logic [32:0] q[$];
    logic [15:0] mcount;

    inst_encoder dut (
        .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm), .ExtSel(ExtSel),
        .out_valid(out_valid), .out_ready(out_ready), .inst(inst), .err(err),
        .count(count)
    );

    always #5 CLK = ~CLK;

    // Expected word computed with plain arithmetic on field positions.
    function automatic logic [32:0] model(input logic [2:0] f, input logic [31:0] im,
                                          input logic es);
        int unsigned w, op, d, s1, s2, f3, f7;
        int          s;
        logic        e;
        op = opcode; d = rd; s1 = rs1; s2 = rs2; f3 = funct3; f7 = funct7;
        s = int'(im);
        w = 0; e = 1'b0;
        case (f)
            3'd0, 3'd1: begin
                if (f == 3'd0) w = op + (d << 7) + (f3 << 12) + (s1 << 15) + ((im & 'hFFF) << 20);
                else w = op + ((im & 31) << 7) + (f3 << 12) + (s1 << 15) + (s2 << 20)
                         + (((im >> 5) & 127) << 25);
                e = es ? (s < -2048 || s > 2047) : (im > 4095);
            end
            3'd2: begin
                w = op + (((im >> 11) & 1) << 7) + (((im >> 1) & 15) << 8) + (f3 << 12)
                    + (s1 << 15) + (s2 << 20) + (((im >> 5) & 63) << 25) + (((im >> 12) & 1) << 31);
                e = im[0] || (es ? (s < -4096 || s > 4095) : (im > 8191));
            end
            3'd3: begin
                w = op + (d << 7) + ((im & 'hFFFFF) << 12);
                e = (im >= 32'h0010_0000);
            end
            3'd4: begin
                w = op + (d << 7) + (((im >> 12) & 255) << 12) + (((im >> 11) & 1) << 20)
                    + (((im >> 1) & 1023) << 21) + (((im >> 20) & 1) << 31);
                e = im[0] || (es ? (s < -1048576 || s > 1048575) : (im >= 32'h0020_0000));
            end
            3'd5: begin
                w = op + (d << 7) + (f3 << 12) + (s1 << 15) + (s2 << 20) + (f7 << 25);
                e = 1'b0;
            end
            default: begin
                w = 0; e = 1'b1;
            end
        endcase
        return {e, w[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model with the pre-edge inputs, then check.
    task automatic cycle();
        logic acc, pp;
        logic [32:0] w;
        acc = in_valid && !Reset && (q.size() < 2);
        pp  = out_ready && (q.size() > 0);
        w   = model(fmt, imm, ExtSel);
        @(posedge CLK);
        if (Reset) begin
            q.delete();
            mcount = 16'h0;
        end else begin
            if (pp) begin
                void'(q.pop_front());
                mcount = mcount + 16'h1;
            end
            if (acc) q.push_back(w);
        end
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
        chk("in_ready", {31'b0, in_ready}, {31'b0, Reset || q.size() < 2});
        chk("count", {16'b0, count}, {16'b0, mcount});
        if (q.size() > 0) begin
            chk("inst", inst, q[0][31:0]);
            chk("err", {31'b0, err}, {31'b0, q[0][32]});
        end
    endtask

    task automatic req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                       input logic [4:0] a, input logic [4:0] b, input logic [2:0] f3,
                       input logic [31:0] im, input logic es);
        in_valid = 1'b1; fmt = f; opcode = op; rd = d; rs1 = a; rs2 = b;
        funct3 = f3; funct7 = 7'h0; imm = im; ExtSel = es;
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();
        out_ready = 1'b0;
    endtask

    initial begin
        mcount = 16'h0;
        Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        req(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0, 1'b0);
        in_valid = 1'b0;
        repeat (2) cycle();
        Reset = 1'b0;
        chk("rst_inst", inst, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        cycle();

        // I with negative immediate, visible one cycle after acceptance.
        req(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF, 1'b1);
        cycle(); in_valid = 1'b0;
        chk("i_inst", inst, 32'hFFF0_0093);
        chk("i_err", {31'b0, err}, 32'h0);
        chk("i_lat", {31'b0, out_valid}, 32'h1);
        drain();

        req(3'd1, 7'b0100011, 5'd0, 5'd3, 5'd2, 3'b010, 32'd8, 1'b1);
        cycle(); in_valid = 1'b0;
        chk("s_inst", inst, 32'h0021_A423);
        chk("s_err", {31'b0, err}, 32'h0);
        drain();

        req(3'd2, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC, 1'b1);
        cycle(); in_valid = 1'b0;
        chk("b_inst", inst, 32'hFE00_0EE3);
        chk("b_err", {31'b0, err}, 32'h0);
        drain();
        req(3'd2, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3, 1'b1);
        cycle(); in_valid = 1'b0;
        chk("b_odd_err", {31'b0, err}, 32'h1);
        drain();

        req(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd4095, 1'b0);
        cycle(); in_valid = 1'b0;
        chk("i_u_imm", {20'b0, inst[31:20]}, 32'hFFF);
        chk("i_u_err", {31'b0, err}, 32'h0);
        drain();
        req(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd4096, 1'b0);
        cycle(); in_valid = 1'b0;
        chk("i_u_ovf", {31'b0, err}, 32'h1);
        drain();

        req(3'd6, 7'h7F, 5'd1, 5'd2, 5'd3, 3'd1, 32'h0, 1'b0);
        cycle(); in_valid = 1'b0;
        chk("ill_inst", inst, 32'h0);
        chk("ill_err", {31'b0, err}, 32'h1);
        drain();

        // Backpressure: third request held until the consumer drains.
        Reset = 1'b1; cycle(); Reset = 1'b0;
        req(3'd5, 7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 32'h0, 1'b0);
        cycle(); rd = 5'd7; cycle(); rd = 5'd8;
        chk("full_rdy", {31'b0, in_ready}, 32'h0);
        cycle(); cycle();
        chk("held_rdy", {31'b0, in_ready}, 32'h0);
        out_ready = 1'b1;
        cycle(); cycle(); in_valid = 1'b0;
        repeat (3) cycle();
        chk("bp_count", {16'b0, count}, 32'd3);
        out_ready = 1'b0;

        // Reset with two entries queued discards them.
        req(3'd3, 7'h37, 5'd9, 5'd0, 5'd0, 3'd0, 32'h12345, 1'b0);
        cycle(); cycle(); in_valid = 1'b0;
        Reset = 1'b1; cycle(); Reset = 1'b0; out_ready = 1'b1;
        chk("rst_ov", {31'b0, out_valid}, 32'h0);
        chk("rst_cnt", {16'b0, count}, 32'h0);
        chk("rst_rdy", {31'b0, in_ready}, 32'h1);
        cycle();
        chk("no_stale", {31'b0, out_valid}, 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            Reset     = $urandom_range(0, 60) == 0;
            fmt = 3'($urandom_range(0, 7)); opcode = 7'($urandom); rd = 5'($urandom);
            rs1 = 5'($urandom); rs2 = 5'($urandom); funct3 = 3'($urandom);
            funct7 = 7'($urandom); ExtSel = 1'($urandom);
            case ($urandom_range(0, 3))
                0: imm = $urandom;
                1: imm = 32'(int'($urandom_range(0, 16383)) - 8192);
                2: imm = $urandom_range(0, 32'h0030_0000);
                default: imm = 32'hFFE0_0000 | $urandom_range(0, 32'h003F_FFFF);
            endcase
            cycle();
        end
        Reset = 1'b0; in_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
